// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the vgachargen memories and their APB front-end.
// The optional ID register is enabled by VGACHARGEN_APB_ID_REG_EN.
package vgachargen_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 10;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int unsigned NUM_MEMS       = 3;

    localparam logic [APB_DATA_WIDTH-1:0] APB_ID_VALUE = 32'h5647_4131;

    typedef enum logic [1:0] {
        REG_CHAR_MAP  = 2'd0,
        REG_COL_MAP   = 2'd1,
        REG_CHAR_TIFF = 2'd2,
        REG_INVALID   = 2'd3
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_ACK     = 3'd1,
        ST_RD_ISSUE   = 3'd2,
        ST_RD_CAPTURE = 3'd3,
        ST_RD_ACK     = 3'd4,
        ST_ERR_ACK    = 3'd5
    } state_e;

    // Write-side payload driven towards one vgachargen memory port.
    typedef struct packed {
        logic                      we;
        logic [APB_STRB_WIDTH-1:0] be;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } mem_wr_t;

endpackage

// File: rtl/apb_vgachargen_decode.sv
// Combinational APB byte address -> memory region, word address and validity.
// With VGACHARGEN_APB_ID_REG_EN defined, also flags the region-3 offset-0 ID slot.
module apb_vgachargen_decode
    import vgachargen_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned MEM_ADDR_WIDTH = vgachargen_pkg::MEM_ADDR_WIDTH,
    parameter int unsigned REGION_SHIFT   = 12
) (
    input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
    output region_e                   o_region_c,
    output logic [MEM_ADDR_WIDTH-1:0] o_word_addr_c,
    output logic                      o_valid_c,
    output logic                      o_id_hit_c
);

    logic       w_upper_set;
    logic [1:0] w_region_raw;
    logic       w_offset_zero;
    logic       w_unused;

    // Any address bit above the region field makes the access invalid.
    generate
        if (APB_ADDR_WIDTH > REGION_SHIFT + 2) begin : g_upper
            assign w_upper_set = |i_paddr[APB_ADDR_WIDTH-1:REGION_SHIFT+2];
        end else begin : g_no_upper
            assign w_upper_set = 1'b0;
        end
    endgenerate

    assign w_region_raw  = i_paddr[REGION_SHIFT+1:REGION_SHIFT];
    assign w_offset_zero = ~|i_paddr[REGION_SHIFT-1:2];

    assign o_region_c    = w_upper_set ? REG_INVALID : region_e'(w_region_raw);
    assign o_word_addr_c = i_paddr[MEM_ADDR_WIDTH+1:2];
    assign o_valid_c     = (o_region_c != REG_INVALID);

`ifdef VGACHARGEN_APB_ID_REG_EN
    assign o_id_hit_c = (w_region_raw == 2'd3) & ~w_upper_set & w_offset_zero;
    assign w_unused   = ^i_paddr[1:0];
`else
    assign o_id_hit_c = 1'b0;
    assign w_unused   = ^{i_paddr[1:0], w_offset_zero};
`endif

endmodule

// File: rtl/apb_vgachargen_bridge.sv
// APB4 slave that sequences the three vgachargen synchronous-read memory ports.
// Define VGACHARGEN_APB_ID_REG_EN to expose the read-only ID register in region 3.
module apb_vgachargen_bridge
    import vgachargen_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned MEM_ADDR_WIDTH = vgachargen_pkg::MEM_ADDR_WIDTH,
    parameter int unsigned REGION_SHIFT   = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic [3:0]                pstrb_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,

    output logic [MEM_ADDR_WIDTH-1:0] char_map_addr_o,
    output logic                      char_map_we_o,
    output logic [3:0]                char_map_be_o,
    output logic [31:0]               char_map_wdata_o,
    input  logic [31:0]               char_map_rdata_i,

    output logic [MEM_ADDR_WIDTH-1:0] col_map_addr_o,
    output logic                      col_map_we_o,
    output logic [3:0]                col_map_be_o,
    output logic [31:0]               col_map_wdata_o,
    input  logic [31:0]               col_map_rdata_i,

    output logic [MEM_ADDR_WIDTH-1:0] char_tiff_addr_o,
    output logic                      char_tiff_we_o,
    output logic [3:0]                char_tiff_be_o,
    output logic [31:0]               char_tiff_wdata_o,
    input  logic [31:0]               char_tiff_rdata_i
);

    state_e                                   r_state;
    state_e                                   w_state_nxt;
    logic                                     r_pready;
    logic                                     w_pready_nxt;
    logic                                     r_pslverr;
    logic                                     w_pslverr_nxt;
    logic [31:0]                              r_prdata;
    logic [31:0]                              w_prdata_nxt;
    region_e                                  r_rd_sel;
    region_e                                  w_rd_sel_nxt;
    logic [NUM_MEMS-1:0][MEM_ADDR_WIDTH-1:0]  r_addr;
    logic [NUM_MEMS-1:0][MEM_ADDR_WIDTH-1:0]  w_addr_nxt;
    mem_wr_t [NUM_MEMS-1:0]                   r_wr;
    mem_wr_t [NUM_MEMS-1:0]                   w_wr_nxt;

    region_e                                  w_region;
    logic [1:0]                               w_sel;
    logic [MEM_ADDR_WIDTH-1:0]                w_word_addr;
    logic                                     w_valid;
    logic                                     w_id_hit;
    logic                                     w_access;
    logic [31:0]                              w_rdata_sel;

    apb_vgachargen_decode #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .REGION_SHIFT   (REGION_SHIFT)
    ) u_decode (
        .i_paddr       (paddr_i),
        .o_region_c    (w_region),
        .o_word_addr_c (w_word_addr),
        .o_valid_c     (w_valid),
        .o_id_hit_c    (w_id_hit)
    );

    assign w_access = psel_i & penable_i;
    assign w_sel    = 2'(w_region);

    // Read-data return path from the memory latched at issue time.
    always_comb begin
        w_rdata_sel = '0;
        case (r_rd_sel)
            REG_CHAR_MAP:  w_rdata_sel = char_map_rdata_i;
            REG_COL_MAP:   w_rdata_sel = col_map_rdata_i;
            REG_CHAR_TIFF: w_rdata_sel = char_tiff_rdata_i;
            default:       w_rdata_sel = '0;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = r_prdata;
        w_rd_sel_nxt  = r_rd_sel;
        w_addr_nxt    = r_addr;
        w_wr_nxt      = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_id_hit && !pwrite_i) begin
                        w_state_nxt  = ST_ERR_ACK;
                        w_pready_nxt = 1'b1;
                        w_prdata_nxt = APB_ID_VALUE;
                    end else if (!w_valid) begin
                        w_state_nxt   = ST_ERR_ACK;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                        w_prdata_nxt  = '0;
                    end else if (pwrite_i) begin
                        w_state_nxt       = ST_WR_ACK;
                        w_pready_nxt      = 1'b1;
                        w_addr_nxt[w_sel] = w_word_addr;
                        w_wr_nxt[w_sel]   = '{we: |pstrb_i, be: pstrb_i, wdata: pwdata_i};
                    end else begin
                        w_state_nxt       = ST_RD_ISSUE;
                        w_addr_nxt[w_sel] = w_word_addr;
                        w_rd_sel_nxt      = w_region;
                    end
                end
            end
            ST_RD_ISSUE: begin
                w_state_nxt = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                w_state_nxt  = ST_RD_ACK;
                w_pready_nxt = 1'b1;
                w_prdata_nxt = w_rdata_sel;
            end
            ST_WR_ACK, ST_RD_ACK, ST_ERR_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_rd_sel  <= REG_CHAR_MAP;
            r_addr    <= '0;
            r_wr      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
            r_rd_sel  <= w_rd_sel_nxt;
            r_addr    <= w_addr_nxt;
            r_wr      <= w_wr_nxt;
        end
    end

    assign prdata_o  = r_prdata;
    assign pready_o  = r_pready;
    assign pslverr_o = r_pslverr;

    assign char_map_addr_o   = r_addr[0];
    assign char_map_we_o     = r_wr[0].we;
    assign char_map_be_o     = r_wr[0].be;
    assign char_map_wdata_o  = r_wr[0].wdata;

    assign col_map_addr_o    = r_addr[1];
    assign col_map_we_o      = r_wr[1].we;
    assign col_map_be_o      = r_wr[1].be;
    assign col_map_wdata_o   = r_wr[1].wdata;

    assign char_tiff_addr_o  = r_addr[2];
    assign char_tiff_we_o    = r_wr[2].we;
    assign char_tiff_be_o    = r_wr[2].be;
    assign char_tiff_wdata_o = r_wr[2].wdata;

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Directed self-checking bench for apb_vgachargen_bridge with behavioural vgachargen memories.
module tb_apb_vgachargen_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        psel_i, penable_i, pwrite_i;
    logic [15:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;

    logic [9:0]  char_map_addr_o, col_map_addr_o, char_tiff_addr_o;
    logic        char_map_we_o, col_map_we_o, char_tiff_we_o;
    logic [3:0]  char_map_be_o, col_map_be_o, char_tiff_be_o;
    logic [31:0] char_map_wdata_o, col_map_wdata_o, char_tiff_wdata_o;
    logic [31:0] char_map_rdata_i, col_map_rdata_i, char_tiff_rdata_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_cm  [1024];
    logic [31:0] mem_col [1024];
    logic [31:0] mem_tf  [1024];
    int we_cnt_cm  = 0;
    int we_cnt_col = 0;
    int we_cnt_tf  = 0;

    apb_vgachargen_bridge dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .psel_i            (psel_i),
        .penable_i         (penable_i),
        .pwrite_i          (pwrite_i),
        .paddr_i           (paddr_i),
        .pwdata_i          (pwdata_i),
        .pstrb_i           (pstrb_i),
        .prdata_o          (prdata_o),
        .pready_o          (pready_o),
        .pslverr_o         (pslverr_o),
        .char_map_addr_o   (char_map_addr_o),
        .char_map_we_o     (char_map_we_o),
        .char_map_be_o     (char_map_be_o),
        .char_map_wdata_o  (char_map_wdata_o),
        .char_map_rdata_i  (char_map_rdata_i),
        .col_map_addr_o    (col_map_addr_o),
        .col_map_we_o      (col_map_we_o),
        .col_map_be_o      (col_map_be_o),
        .col_map_wdata_o   (col_map_wdata_o),
        .col_map_rdata_i   (col_map_rdata_i),
        .char_tiff_addr_o  (char_tiff_addr_o),
        .char_tiff_we_o    (char_tiff_we_o),
        .char_tiff_be_o    (char_tiff_be_o),
        .char_tiff_wdata_o (char_tiff_wdata_o),
        .char_tiff_rdata_i (char_tiff_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read, byte-enabled memories as seen by vgachargen.
    always @(posedge clk_i) begin
        if (char_map_we_o) begin
            for (int b = 0; b < 4; b++)
                if (char_map_be_o[b]) mem_cm[char_map_addr_o][b*8 +: 8] <= char_map_wdata_o[b*8 +: 8];
            we_cnt_cm <= we_cnt_cm + 1;
        end
        char_map_rdata_i <= mem_cm[char_map_addr_o];
    end

    always @(posedge clk_i) begin
        if (col_map_we_o) begin
            for (int b = 0; b < 4; b++)
                if (col_map_be_o[b]) mem_col[col_map_addr_o][b*8 +: 8] <= col_map_wdata_o[b*8 +: 8];
            we_cnt_col <= we_cnt_col + 1;
        end
        col_map_rdata_i <= mem_col[col_map_addr_o];
    end

    always @(posedge clk_i) begin
        if (char_tiff_we_o) begin
            for (int b = 0; b < 4; b++)
                if (char_tiff_be_o[b]) mem_tf[char_tiff_addr_o][b*8 +: 8] <= char_tiff_wdata_o[b*8 +: 8];
            we_cnt_tf <= we_cnt_tf + 1;
        end
        char_tiff_rdata_i <= mem_tf[char_tiff_addr_o];
    end

    function automatic logic [31:0] sweep_word(input int i);
        return 32'hC0DE_5A00 ^ (32'(i) * 32'h0001_0103);
    endfunction

    // One APB transfer; must be called at a negedge. lat counts cycles from access phase to pready.
    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic slverr, output int lat);
        bit done;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = wr;
        paddr_i   = addr;
        pwdata_i  = wdata;
        pstrb_i   = strb;
        @(negedge clk_i);
        penable_i = 1'b1;
        done = 1'b0;
        lat  = 0;
        while (!done && lat < 8) begin
            @(negedge clk_i);
            lat++;
            done = pready_o;
        end
        if (!done) lat = 99;
        rdata     = prdata_o;
        slverr    = pslverr_o;
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_cm[i] = '0; mem_col[i] = '0; mem_tf[i] = '0;
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL rst_pready got=%b exp=0", pready_o); end
        checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL rst_pslverr got=%b exp=0", pslverr_o); end
        checks++; if (prdata_o !== 32'h0) begin failures++; $display("FAIL rst_prdata got=%h exp=0", prdata_o); end
        checks++; if ({char_map_we_o, col_map_we_o, char_tiff_we_o} !== 3'b000) begin
            failures++; $display("FAIL rst_we got=%b exp=000", {char_map_we_o, col_map_we_o, char_tiff_we_o}); end
        checks++; if ({char_map_addr_o, col_map_addr_o, char_tiff_addr_o} !== 30'h0) begin
            failures++; $display("FAIL rst_addr got=%h exp=0", {char_map_addr_o, col_map_addr_o, char_tiff_addr_o}); end
        checks++; if ({char_map_be_o, col_map_be_o, char_tiff_be_o} !== 12'h0) begin
            failures++; $display("FAIL rst_be got=%h exp=0", {char_map_be_o, col_map_be_o, char_tiff_be_o}); end
    endtask

    task automatic test_write_col();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1'b1, 16'h1008, 32'hA5A5_A5A5, 4'hF, rd, err, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL wr_col_lat got=%0d exp=1", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_col_slverr got=%b exp=0", err); end
        checks++; if (col_map_we_o !== 1'b1) begin failures++; $display("FAIL wr_col_we got=%b exp=1", col_map_we_o); end
        checks++; if (col_map_addr_o !== 10'd2) begin failures++; $display("FAIL wr_col_addr got=%0d exp=2", col_map_addr_o); end
        checks++; if (col_map_be_o !== 4'hF) begin failures++; $display("FAIL wr_col_be got=%h exp=f", col_map_be_o); end
        checks++; if (col_map_wdata_o !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_col_wdata got=%h exp=a5a5a5a5", col_map_wdata_o); end
        checks++; if ({char_map_we_o, char_tiff_we_o} !== 2'b00) begin
            failures++; $display("FAIL wr_col_other_we got=%b exp=00", {char_map_we_o, char_tiff_we_o}); end
        @(negedge clk_i);
        checks++; if (col_map_we_o !== 1'b0 || col_map_be_o !== 4'h0) begin
            failures++; $display("FAIL wr_col_we_drop got=%b/%h exp=0/0", col_map_we_o, col_map_be_o); end
        checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL wr_col_pready_pulse got=%b exp=0", pready_o); end
        checks++; if (mem_col[2] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_col_mem got=%h exp=a5a5a5a5", mem_col[2]); end
    endtask

    task automatic test_write_read_tiff();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1'b1, 16'h2014, 32'h1234_5678, 4'hF, rd, err, lat);
        checks++; if (char_tiff_addr_o !== 10'd5) begin failures++; $display("FAIL wr_tf_addr got=%0d exp=5", char_tiff_addr_o); end
        apb_xfer(1'b0, 16'h2014, 32'h0, 4'h0, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_tf_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL rd_tf_data got=%h exp=12345678", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd_tf_slverr got=%b exp=0", err); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd; logic err; int lat; int cnt0;
        apb_xfer(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, rd, err, lat);
        apb_xfer(1'b1, 16'h0000, 32'h0000_AB00, 4'b0010, rd, err, lat);
        checks++; if (char_map_be_o !== 4'b0010) begin failures++; $display("FAIL bs_be got=%b exp=0010", char_map_be_o); end
        apb_xfer(1'b0, 16'h0002, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'hFFFF_ABFF) begin failures++; $display("FAIL bs_readback got=%h exp=ffffabff", rd); end
        cnt0 = we_cnt_cm;
        apb_xfer(1'b1, 16'h0000, 32'h0000_0000, 4'h0, rd, err, lat);
        checks++; if (lat !== 1 || err !== 1'b0) begin failures++; $display("FAIL bs_zero_strb_ack got lat=%0d err=%b exp lat=1 err=0", lat, err); end
        checks++; if (char_map_we_o !== 1'b0) begin failures++; $display("FAIL bs_zero_strb_we got=%b exp=0", char_map_we_o); end
        @(negedge clk_i);
        checks++; if (we_cnt_cm !== cnt0) begin failures++; $display("FAIL bs_zero_strb_cnt got=%0d exp=%0d", we_cnt_cm, cnt0); end
        apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'hFFFF_ABFF) begin failures++; $display("FAIL bs_zero_strb_data got=%h exp=ffffabff", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat; int cnt0;
        logic [31:0] exp_id_data; logic exp_id_err;
`ifdef VGACHARGEN_APB_ID_REG_EN
        exp_id_data = 32'h5647_4131; exp_id_err = 1'b0;
`else
        exp_id_data = 32'h0;         exp_id_err = 1'b1;
`endif
        cnt0 = we_cnt_cm + we_cnt_col + we_cnt_tf;
        apb_xfer(1'b0, 16'h3004, 32'h0, 4'h0, rd, err, lat);
        checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL err_3004 got lat=%0d err=%b exp lat=1 err=1", lat, err); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_3004_prdata got=%h exp=0", rd); end
        apb_xfer(1'b1, 16'h4000, 32'hDEAD_BEEF, 4'hF, rd, err, lat);
        checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL err_4000 got lat=%0d err=%b exp lat=1 err=1", lat, err); end
        checks++; if ({char_map_we_o, col_map_we_o, char_tiff_we_o} !== 3'b000) begin
            failures++; $display("FAIL err_4000_we got=%b exp=000", {char_map_we_o, col_map_we_o, char_tiff_we_o}); end
        apb_xfer(1'b1, 16'h3000, 32'h1111_2222, 4'hF, rd, err, lat);
        checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL err_id_write got lat=%0d err=%b exp lat=1 err=1", lat, err); end
        apb_xfer(1'b0, 16'h3000, 32'h0, 4'h0, rd, err, lat);
        checks++; if (lat !== 1 || err !== exp_id_err) begin failures++; $display("FAIL id_read_ack got lat=%0d err=%b exp lat=1 err=%b", lat, err, exp_id_err); end
        checks++; if (rd !== exp_id_data) begin failures++; $display("FAIL id_read_data got=%h exp=%h", rd, exp_id_data); end
        @(negedge clk_i);
        checks++; if (we_cnt_cm + we_cnt_col + we_cnt_tf !== cnt0) begin
            failures++; $display("FAIL err_no_strobe got=%0d exp=%0d", we_cnt_cm + we_cnt_col + we_cnt_tf, cnt0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat; int c_cm, c_col, c_tf;
        c_cm = we_cnt_cm; c_col = we_cnt_col; c_tf = we_cnt_tf;
        for (int i = 0; i < 600; i++)
            apb_xfer(1'b1, 16'h1000 + 16'(i * 4), sweep_word(i), 4'hF, rd, err, lat);
        @(negedge clk_i);
        checks++; if (we_cnt_col - c_col !== 600) begin failures++; $display("FAIL b2b_col_strobes got=%0d exp=600", we_cnt_col - c_col); end
        for (int i = 0; i < 600; i++) begin
            apb_xfer(1'b0, 16'h1000 + 16'(i * 4), 32'h0, 4'h0, rd, err, lat);
            checks++;
            if (rd !== sweep_word(i) || lat !== 3 || err !== 1'b0) begin
                failures++; $display("FAIL b2b_read[%0d] got=%h lat=%0d err=%b exp=%h lat=3 err=0", i, rd, lat, err, sweep_word(i));
            end
        end
        @(negedge clk_i);
        checks++; if (we_cnt_col - c_col !== 600 || we_cnt_cm !== c_cm || we_cnt_tf !== c_tf) begin
            failures++; $display("FAIL b2b_extra_strobes got col=%0d cm=%0d tf=%0d exp col=600 cm=0 tf=0",
                                 we_cnt_col - c_col, we_cnt_cm - c_cm, we_cnt_tf - c_tf); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd; logic err; int lat;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 16'h1004; pstrb_i = 4'h0;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL rst_mid_pready got=%b exp=0", pready_o); end
        checks++; if ({char_map_we_o, col_map_we_o, char_tiff_we_o} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_we got=%b exp=000", {char_map_we_o, col_map_we_o, char_tiff_we_o}); end
        checks++; if (prdata_o !== 32'h0) begin failures++; $display("FAIL rst_mid_prdata got=%h exp=0", prdata_o); end
        apb_xfer(1'b0, 16'h2014, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'h1234_5678 || lat !== 3) begin
            failures++; $display("FAIL rst_mid_reread got=%h lat=%0d exp=12345678 lat=3", rd, lat); end
        apb_xfer(1'b0, 16'h101C, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== sweep_word(7)) begin failures++; $display("FAIL rst_mid_col7 got=%h exp=%h", rd, sweep_word(7)); end
    endtask

    initial begin
        test_reset();
        test_write_col();
        test_write_read_tiff();
        test_byte_strobe();
        test_errors();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_vgachargen_bridge.md
Name: apb_vgachargen_bridge

Overview:
APB slave front-end for vgachargen. Decodes a single APB4 slave window into the three vgachargen memory ports (char_map, col_map, char_tiff). Sequences their synchronous-read, byte-enabled write interfaces. Sits directly upstream of vgachargen in the sys_clk domain, driving its *_addr_i/_we_i/_be_i/_wdata_i and consuming its *_rdata_o.

Parameters:
APB_ADDR_WIDTH, 16, width of paddr_i (byte address)
MEM_ADDR_WIDTH, 10, word address width of each vgachargen memory
REGION_SHIFT, 12, paddr bit where region select starts (4 KiB per region)

Ports:
clk_i  in  1  system clock (vgachargen clk_i domain)
rst_i  in  1  synchronous reset, active-high
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  APB_ADDR_WIDTH  APB byte address
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
char_map_addr_o / col_map_addr_o / char_tiff_addr_o  out  MEM_ADDR_WIDTH  word address, one per memory
char_map_we_o / col_map_we_o / char_tiff_we_o  out  1  write enable
char_map_be_o / col_map_be_o / char_tiff_be_o  out  4  byte enables
char_map_wdata_o / col_map_wdata_o / char_tiff_wdata_o  out  32  write data
char_map_rdata_i / col_map_rdata_i / char_tiff_rdata_i  in  32  read data, valid one clk_i after address

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: all outputs 0; state IDLE.
- Decode: region = paddr_i[REGION_SHIFT+1:REGION_SHIFT]. 0=char_map, 1=col_map, 2=char_tiff, 3=invalid.
- Word address = paddr_i[MEM_ADDR_WIDTH+1:2]. paddr_i[1:0] ignored. Any set bit above REGION_SHIFT+1 -> invalid.
- FSM states: IDLE, WR_ACK, RD_ISSUE, RD_CAPTURE, RD_ACK, ERR_ACK.
- Access detection is in IDLE only: psel_i & penable_i at cycle T. Setup phase alone has no effect.
- Write, valid region, at T:
  - T+1: state WR_ACK. Selected memory gets addr, wdata = pwdata_i, be = pstrb_i, we = |pstrb_i, held for exactly one cycle. pready_o = 1, pslverr_o = 0.
  - pstrb_i == 0: completes OKAY with we = 0.
- Read, valid region, at T:
  - T+1: RD_ISSUE, addr registered to the selected memory.
  - T+2: RD_CAPTURE, prdata register loads the selected rdata.
  - T+3: RD_ACK, pready_o = 1, prdata_o valid.
  - Read latency is 3 cycles from access phase.
- Invalid region, at T: T+1 ERR_ACK, pready_o = 1, pslverr_o = 1, prdata_o = 0. No we asserted on any memory.
- All ACK states return to IDLE. pready_o is a single-cycle pulse, so the next transfer's access phase is accepted no earlier than the cycle after pready_o.
- Idle outputs:
  - we_o and be_o are 0 outside WR_ACK.
  - addr_o of unselected memories keep their last value.
  - prdata_o holds until the next read capture or error.
- Only the selected memory sees we; the other two never strobe.
- Reset asserted mid-transfer: next cycle is IDLE with pready_o = 0 and all we_o = 0. The pending transfer is dropped (master re-issues).
- psel_i dropped mid-wait (protocol violation): the transfer still completes internally, and pready_o pulses regardless.

Optional Feature:
VGACHARGEN_APB_ID_REG_EN
- Defined: region 3 offset 0x0 is a read-only ID register returning 32'h5647_4131. Reading it takes the ERR_ACK timing (T+1) with pslverr_o = 0. Writing it, or accessing any other region-3 offset, returns pslverr_o = 1.
- Undefined: all of region 3 returns pslverr_o = 1.

Decomposition:
- vgachargen_pkg gains:
  - region enum (REG_CHAR_MAP, REG_COL_MAP, REG_CHAR_TIFF, REG_INVALID)
  - FSM state enum
  - ID constant
  - MEM_ADDR_WIDTH constant, shared with vgachargen.
- Sub-module apb_vgachargen_decode: combinational paddr -> region + word address + valid.

Test Plan:
- Write paddr 0x1008, pwdata 0xA5A5A5A5, pstrb 4'hF -> col_map_we_o = 1 and col_map_addr_o = 2 for one cycle at T+1, pready_o = 1, pslverr_o = 0.
- Write char_tiff word 5 = 0x12345678 then read paddr 0x2014 -> pready_o at T+3, prdata_o = 0x12345678.
- Byte-strobe write pstrb 4'b0010 to char_map word 0 over 0xFFFFFFFF, data 0x0000AB00 -> readback 0xFFFFABFF. pstrb 0 write -> no we, pready_o = 1.
- Access paddr 0x3004 (and 0x4000) -> pready_o T+1, pslverr_o = 1, no memory we. With VGACHARGEN_APB_ID_REG_EN, read 0x3000 -> 0x56474131.
- Back-to-back full sweeps: write 600 words to col_map, then read back -> every word matches, no extra strobes.
- Assert rst_i during RD_CAPTURE -> next cycle pready_o = 0, state IDLE. A subsequent read returns correct data.
